fixed_latency_valid_tracker: RTL and testbench

//  Downstream-side companion for fixed-latency, non-stallable pipeline stages.
//  - Tracks in-flight tokens with a LATENCY-deep valid shift register.
//  - Captures each dp_result on the cycle it emerges into a DEPTH-entry output FIFO.
//  - Drives out_valid/out_data to the next stage and honours out_ready backpressure.
//  - Credit-gates in_ready so the stallless datapath can never overflow the FIFO.

---
 rtl/fixed_latency_valid_tracker.sv | 138 +++++++++++++
 tb/tb_fixed_latency_valid_tracker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_latency_valid_tracker.sv
// Valid/credit tracker for a fixed-latency, non-stallable datapath: follows tokens in flight,
// captures results into an output FIFO and gates new launches so that FIFO can never overflow.

module fixed_latency_valid_tracker_chk #(
    parameter int LATENCY = 7,
    parameter int DEPTH   = 8,
    parameter int CW      = 4
) (
    input logic               clk,
    input logic               rst,
    input logic               launch,
    input logic               push,
    input logic               pop,
    input logic [LATENCY-1:0] vsr,
    input logic [CW-1:0]      credits,
    input logic [CW-1:0]      count
);
    int inflight_s;

    // population count of the valid shift register
    always_comb begin
        inflight_s = 32'sd0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_s = inflight_s + int'(vsr[i]);
        end
    end

    a_credit_balance: assert property (@(posedge clk) disable iff (rst)
        (int'(credits) + inflight_s + int'(count)) == DEPTH);
    a_no_credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !launch && (int'(credits) == DEPTH)));
    a_no_credit_underflow: assert property (@(posedge clk) disable iff (rst)
        !(launch && (credits == {CW{1'b0}})));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (int'(count) == DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == {CW{1'b0}})));
endmodule

module fixed_latency_valid_tracker #(
    parameter int LATENCY = 7,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       dp_launch,
    input  logic [DATA_W-1:0]          dp_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] credits
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] ALL_CREDITS = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT   = PW'(DEPTH - 1);

    logic [LATENCY-1:0] vsr_r;
    logic [DATA_W-1:0]  mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      credits_r;
    logic               launch_s;
    logic               push_s;
    logic               pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == LAST_SLOT) ? {PW{1'b0}} : (p + PW'(1));
    endfunction

    // handshake decode; in_ready depends only on the credit register
    always_comb begin
        launch_s = in_valid & in_ready & ~rst;
        push_s   = vsr_r[LATENCY-1];
        pop_s    = out_valid & out_ready;
    end

    assign in_ready  = (credits_r != {CW{1'b0}});
    assign out_valid = (count_r != {CW{1'b0}});
    assign out_data  = mem_r[rd_ptr_r];
    assign dp_launch = launch_s;
    assign credits   = credits_r;

    // token tracking, FIFO pointers/count and credit bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            vsr_r     <= {LATENCY{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            credits_r <= ALL_CREDITS;
        end else begin
            vsr_r <= (vsr_r << 1'b1) | LATENCY'(launch_s);
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({launch_s, pop_s})
                2'b10:   credits_r <= credits_r - CW'(1);
                2'b01:   credits_r <= credits_r + CW'(1);
                default: credits_r <= credits_r;
            endcase
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // result storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= dp_result;
        end
    end

    fixed_latency_valid_tracker_chk #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .CW      (CW)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .launch  (launch_s),
        .push    (push_s),
        .pop     (pop_s),
        .vsr     (vsr_r),
        .credits (credits_r),
        .count   (count_r)
    );
endmodule

// File: tb/tb_fixed_latency_valid_tracker.sv
// Directed bench for fixed_latency_valid_tracker (LATENCY=7, DEPTH=8) plus a second
// LATENCY=1, DEPTH=3 instance driven randomly and scoreboarded on every cycle.

module tb_fixed_latency_valid_tracker;
    localparam int LAT  = 7;
    localparam int DEP  = 8;
    localparam int LATB = 1;
    localparam int DEPB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, dp_launch, out_valid, out_ready;
    logic [31:0] dp_result, out_data;
    logic [3:0]  credits;
    logic        rst_b, in_valid_b, in_ready_b, dp_launch_b, out_valid_b, out_ready_b;
    logic [31:0] dp_result_b, out_data_b;
    logic [1:0]  credits_b;

    int checks = 0;
    int errors = 0;
    int launches_a = 0;
    int pops_a = 0;
    int cyc_n = 0;
    int base;
    logic        last_launch = 1'b0;
    logic [31:0] pipe_d [LAT];
    logic [31:0] pipe_b;
    logic [31:0] exp_q[$];
    logic [31:0] exp_qb[$];

    fixed_latency_valid_tracker #(.LATENCY(LAT), .DATA_W(32), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .dp_launch(dp_launch),
        .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .credits(credits));

    fixed_latency_valid_tracker #(.LATENCY(LATB), .DATA_W(32), .DEPTH(DEPB)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .dp_launch(dp_launch_b), .dp_result(dp_result_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .credits(credits_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, model the datapath pipes, scoreboard both instances.
    task automatic cyc(input logic iv, input logic ordy, input logic [31:0] d);
        logic [31:0] db, exp_v, nxt_a, nxt_b;
        logic        la, lb;
        db          = $urandom;
        in_valid    = iv;
        out_ready   = ordy;
        dp_result   = pipe_d[LAT-1];
        in_valid_b  = 1'($urandom_range(0, 1));
        out_ready_b = 1'($urandom_range(0, 1));
        dp_result_b = pipe_b;
        #1;
        la = dp_launch;
        lb = dp_launch_b;
        if (!rst && out_valid && out_ready) begin
            pops_a++;
            if (exp_q.size() == 0) chk("a_spurious_out", 32'(out_valid), 32'd0);
            else begin
                exp_v = exp_q.pop_front();
                chk("a_out_data", out_data, exp_v);
            end
        end
        if (la) begin
            exp_q.push_back(d);
            launches_a++;
        end
        if (!rst_b && out_valid_b && out_ready_b) begin
            if (exp_qb.size() == 0) chk("b_spurious_out", 32'(out_valid_b), 32'd0);
            else begin
                exp_v = exp_qb.pop_front();
                chk("b_out_data", out_data_b, exp_v);
            end
        end
        if (lb) exp_qb.push_back(db);
        nxt_a = la ? d : ~32'(cyc_n);
        nxt_b = lb ? db : (32'(cyc_n) ^ 32'h5A5A_5A5A);
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) pipe_d[i] = pipe_d[i-1];
        pipe_d[0] = nxt_a;
        pipe_b    = nxt_b;
        if (rst) exp_q.delete();
        if (rst_b) exp_qb.delete();
        last_launch = la;
        cyc_n++;
        chk("b_credit_balance", 32'(credits_b) + 32'(exp_qb.size()), 32'd3);
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; dp_result = 32'd0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; dp_result_b = 32'd0;
        for (int i = 0; i < LAT; i++) pipe_d[i] = 32'd0;
        pipe_b = 32'd0;
        @(posedge clk);
        #1;

        // reset with in_valid held high: no launch
        cyc(1'b1, 1'b0, 32'h1111_1111);
        chk("rst_no_launch", 32'(last_launch), 32'd0);
        cyc(1'b1, 1'b0, 32'h1111_1112);
        rst = 1'b0; rst_b = 1'b0;
        chk("rst_credits", 32'(credits), 32'd8);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(dut.count_r), 32'd0);

        // single token: launch in cycle 0, result in cycle 7, out_valid from cycle 8
        cyc(1'b1, 1'b1, 32'h0000_00A5);
        chk("t1_launch", 32'(last_launch), 32'd1);
        chk("t1_credits_dec", 32'(credits), 32'd7);
        repeat (6) cyc(1'b0, 1'b1, 32'd0);
        chk("t1_not_early", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 32'd0);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", out_data, 32'h0000_00A5);
        chk("t1_credits_held", 32'(credits), 32'd7);
        cyc(1'b0, 1'b1, 32'd0);
        chk("t1_credits_back", 32'(credits), 32'd8);
        chk("t1_empty", 32'(out_valid), 32'd0);

        // stream 32 tokens with out_ready high
        base = launches_a;
        for (int i = 0; i < 80 && launches_a < base + 32; i++) cyc(1'b1, 1'b1, 32'hB000_0000 + 32'(i));
        chk("t2_launched", 32'(launches_a - base), 32'd32);
        repeat (12) cyc(1'b0, 1'b1, 32'd0);
        chk("t2_all_popped", 32'(pops_a), 32'(launches_a));
        chk("t2_credits", 32'(credits), 32'd8);
        chk("t2_empty", 32'(out_valid), 32'd0);

        // backpressure: exactly DEPTH launches, then stall with FIFO full
        base = launches_a;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 32'hC000_0000 + 32'(i));
        chk("t3_launches", 32'(launches_a - base), 32'd8);
        chk("t3_credits0", 32'(credits), 32'd0);
        chk("t3_in_ready0", 32'(in_ready), 32'd0);
        chk("t3_count_full", 32'(dut.count_r), 32'd8);
        chk("t3_head", out_data, 32'hC000_0000);
        cyc(1'b1, 1'b1, 32'hC100_0000);
        chk("t3_pop_no_launch", 32'(last_launch), 32'd0);
        chk("t3_credit_ret", 32'(credits), 32'd1);
        chk("t3_count7", 32'(dut.count_r), 32'd7);
        cyc(1'b1, 1'b1, 32'hC100_0001);
        chk("t4_launch_pop", 32'(last_launch), 32'd1);
        chk("t4_credits_hold", 32'(credits), 32'd1);
        chk("t4_count6", 32'(dut.count_r), 32'd6);
        cyc(1'b1, 1'b1, 32'hC100_0002);
        chk("t4_launch_pop2", 32'(last_launch), 32'd1);
        chk("t4_credits_hold2", 32'(credits), 32'd1);
        repeat (20) cyc(1'b0, 1'b1, 32'd0);
        chk("t3_no_loss", 32'(pops_a), 32'(launches_a));
        chk("t3_credits_back", 32'(credits), 32'd8);

        // reset with 3 tokens in flight and 2 in the FIFO
        cyc(1'b1, 1'b0, 32'hD000_0000);
        cyc(1'b1, 1'b0, 32'hD000_0001);
        repeat (5) cyc(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'hD000_0010 + 32'(i));
        chk("t5_pre_count", 32'(dut.count_r), 32'd2);
        chk("t5_pre_credits", 32'(credits), 32'd3);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 32'hDEAD_0000);
        rst = 1'b0;
        chk("t5_rst_no_launch", 32'(last_launch), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_credits", 32'(credits), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 32'd0);
            chk("t5_quiet", 32'(out_valid), 32'd0);
        end
        chk("t5_credits_end", 32'(credits), 32'd8);
        pops_a = 0;
        launches_a = 0;

        // random traffic on both instances
        for (int i = 0; i < 3000; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        repeat (30) cyc(1'b0, 1'b1, 32'd0);
        chk("rand_no_loss", 32'(pops_a), 32'(launches_a));
        chk("rand_credits", 32'(credits), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
